// File: rtl/ds_timing_gen.sv
// Raster timing and test-pattern source for the downscaler datapath.
// Stops only at a frame boundary.
module ds_timing_gen #(
  parameter int WIDTH    = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_pattern,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [WIDTH-1:0] o_r_data,
  output logic [WIDTH-1:0] o_g_data,
  output logic [WIDTH-1:0] o_b_data,
  output logic             o_sof,
  output logic             o_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 4) ? $clog2(H_TOTAL) : 4;
  localparam int VW = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state, w_next;
  logic [HW-1:0]   r_h, w_h;
  logic [VW-1:0]   r_v, w_v;
  logic [BW-1:0]   r_bpos, w_bpos;
  logic [2:0]      r_bar, w_bar;
  logic [1:0]      r_pat, w_pat;
  logic            w_last, w_active, w_de, w_hs, w_vs;
  logic [WIDTH-1:0] w_r, w_g, w_b;

  assign w_last   = (r_h == H_LAST) && (r_v == V_LAST);
  assign w_active = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_en) w_next = S_RUN;
      S_RUN:   if (!i_en) w_next = w_last ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (i_en)        w_next = S_RUN;
        else if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bar index is tracked incrementally so no divider is needed.
  always_comb begin
    w_h    = '0;
    w_v    = '0;
    w_bpos = '0;
    w_bar  = '0;
    if (w_active) begin
      if (r_h == H_LAST) begin
        w_v = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h = r_h + 1'b1;
        w_v = r_v;
        if (r_bpos == B_LAST) begin
          w_bar = r_bar + 3'd1;
        end else begin
          w_bpos = r_bpos + 1'b1;
          w_bar  = r_bar;
        end
      end
    end
  end

  assign w_pat = (r_state == S_RUN && r_h == '0 && r_v == '0)
               ? i_pattern : r_pat;

  assign w_de = w_active && (int'(r_h) < H_ACTIVE)
                         && (int'(r_v) < V_ACTIVE);
  assign w_hs = (int'(r_h) >= H_ACTIVE + H_FP)
             && (int'(r_h) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_vs = (int'(r_v) >= V_ACTIVE + V_FP)
             && (int'(r_v) <  V_ACTIVE + V_FP + V_SYNC);

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_de) begin
      unique case (w_pat)
        2'd0: begin
          w_r = {WIDTH{~r_bar[1]}};
          w_g = {WIDTH{~r_bar[2]}};
          w_b = {WIDTH{~r_bar[0]}};
        end
        2'd1: begin
          w_r = WIDTH'(r_h);
          w_g = WIDTH'(r_h);
          w_b = WIDTH'(r_h);
        end
        2'd2: begin
          w_r = {WIDTH{r_h[3] ^ r_v[3]}};
          w_g = {WIDTH{r_h[3] ^ r_v[3]}};
          w_b = {WIDTH{r_h[3] ^ r_v[3]}};
        end
        default: begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_v      <= '0;
      r_bpos   <= '0;
      r_bar    <= '0;
      r_pat    <= '0;
      o_de     <= 1'b0;
      o_sof    <= 1'b0;
      o_busy   <= 1'b0;
      o_hsync  <= ~SYNC_POL;
      o_vsync  <= ~SYNC_POL;
      o_r_data <= '0;
      o_g_data <= '0;
      o_b_data <= '0;
    end else begin
      r_state  <= w_next;
      r_h      <= w_h;
      r_v      <= w_v;
      r_bpos   <= w_bpos;
      r_bar    <= w_bar;
      r_pat    <= w_pat;
      o_de     <= w_de;
      o_sof    <= w_active && r_h == '0 && r_v == '0;
      o_busy   <= w_active;
      o_hsync  <= (w_active && w_hs) ? SYNC_POL : ~SYNC_POL;
      o_vsync  <= (w_active && w_vs) ? SYNC_POL : ~SYNC_POL;
      o_r_data <= w_r;
      o_g_data <= w_g;
      o_b_data <= w_b;
    end
  end

endmodule
